// File: rtl/aes_enc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_arbiter_if
// Brief    : Request/response handshake bundle between requesters and the
//            shared AES encipher arbiter.
// Revision : 1.0
// ============================================================================
interface aes_enc_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_block;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [127:0]           rsp_block;

    modport master (
        output req_valid, req_block, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_block
    );

    modport slave (
        input  req_valid, req_block, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_block
    );
endinterface
`default_nettype wire

// File: rtl/aes_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_arbiter
// Brief    : Round-robin sharing of one AES encipher core among NUM_REQ
//            requesters, returning id-tagged ciphertext with backpressure.
// Revision : 1.0
// ============================================================================
module aes_enc_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         key_ready,
    input  wire logic         cfg_keylen,
    aes_enc_arbiter_if.slave  bus,
    output logic              core_next,
    output logic              core_keylen,
    output logic [127:0]      core_block,
    input  wire logic         core_ready,
    input  wire logic [127:0] core_new_block,
    output logic [15:0]       ops_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]         c_last_idx = 2'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_one      = NUM_REQ'(1);

    state_t       r_state;
    logic [1:0]   r_last_grant;
    logic [1:0]   r_id;
    logic [127:0] r_blk;
    logic [127:0] r_rsp_block;
    logic         r_keylen;
    logic         r_busy_first;
    logic         r_core_next;
    logic         r_rsp_valid;
    logic [15:0]  r_ops_done;

    logic [1:0]   w_scan;
    logic [1:0]   w_grant;
    logic         w_found;
    logic         w_take;

    // Search upward from the requester after the last grant, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last_grant;
        w_scan  = r_last_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = (w_scan == c_last_idx) ? 2'd0 : w_scan + 2'd1;
            if (!w_found && bus.req_valid[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan;
            end
        end
    end

    // reset_n gates the grant so req_ready reads 0 while reset is held.
    assign w_take = reset_n && (r_state == S_IDLE) && key_ready && core_ready && w_found;

    assign bus.req_ready = w_take ? (c_one << w_grant) : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_block = r_rsp_block;
    assign core_next     = r_core_next;
    assign core_block    = r_blk;
    assign core_keylen   = r_keylen;
    assign ops_done      = r_ops_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_last_idx;
            r_id         <= 2'd0;
            r_blk        <= '0;
            r_rsp_block  <= '0;
            r_keylen     <= 1'b0;
            r_busy_first <= 1'b0;
            r_core_next  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_ops_done   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_blk        <= bus.req_block[128*w_grant +: 128];
                        r_id         <= w_grant;
                        r_keylen     <= cfg_keylen;
                        r_last_grant <= w_grant;
                        r_core_next  <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_core_next  <= 1'b0;
                    r_busy_first <= 1'b1;
                    r_state      <= S_BUSY;
                end
                S_BUSY: begin
                    // The core still shows ready in the first BUSY cycle.
                    r_busy_first <= 1'b0;
                    if (!r_busy_first && core_ready) begin
                        r_rsp_block <= core_new_block;
                        r_ops_done  <= r_ops_done + 16'd1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_enc_arbiter
// Brief    : Self-checking bench for aes_enc_arbiter with a behavioural core
//            stand-in and a round-robin reference model.
// Revision : 1.0
// ============================================================================
module tb_aes_enc_arbiter;

    localparam int NUM_REQ = 4;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         key_ready;
    logic         cfg_keylen;
    logic         core_next;
    logic         core_keylen;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_new_block;
    logic [15:0]  ops_done;

    aes_enc_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    aes_enc_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_ready      (key_ready),
        .cfg_keylen     (cfg_keylen),
        .bus            (bus),
        .core_next      (core_next),
        .core_keylen    (core_keylen),
        .core_block     (core_block),
        .core_ready     (core_ready),
        .core_new_block (core_new_block),
        .ops_done       (ops_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_last;
    int m_ops;

    // Stand-in cipher: the two known-answer vectors, otherwise an invertible scramble.
    function automatic logic [127:0] cipher(input logic [127:0] b, input logic kl);
        if (b == PT && !kl) return CT128;
        if (b == PT && kl)  return CT256;
        return {b[62:0], b[127:63]} ^ (kl ? {4{32'h5a5aa5a5}} : {4{32'h3c3cc3c3}});
    endfunction

    function automatic int exp_grant(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core stand-in: ready stays high one cycle after next, then drops for a random latency.
    logic         c_pend;
    int           c_lat;
    logic [127:0] c_blk;
    logic         c_kl;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready     <= 1'b1;
            c_pend         <= 1'b0;
            c_lat          <= 0;
            core_new_block <= '0;
        end else if (core_next) begin
            c_pend <= 1'b1;
        end else if (c_pend) begin
            c_pend     <= 1'b0;
            core_ready <= 1'b0;
            c_blk      <= core_block;
            c_kl       <= core_keylen;
            c_lat      <= int'($urandom_range(0, 4));
        end else if (!core_ready) begin
            if (c_lat == 0) begin
                core_ready     <= 1'b1;
                core_new_block <= cipher(c_blk, c_kl);
            end else begin
                c_lat <= c_lat - 1;
            end
        end
    end

    int next_pulses = 0;
    int multi_hot   = 0;
    always @(posedge clk) begin
        if (core_next) next_pulses <= next_pulses + 1;
        if (!$onehot0(bus.req_ready)) multi_hot <= multi_hot + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        m_last  = NUM_REQ - 1;
        m_ops   = 0;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_rsp_block"}, bus.rsp_block, 0);
        chk({tag, "_core_next"}, core_next, 0);
        chk({tag, "_core_block"}, core_block, 0);
        chk({tag, "_core_keylen"}, core_keylen, 0);
        chk({tag, "_ops_done"}, ops_done, 0);
    endtask

    // One full operation: grant, start pulse, response with 'hold' cycles of backpressure.
    task automatic run_op(input int hold, input bit keep, output int gid);
        int n, g, p0;
        logic [127:0] d, blk0;
        logic [1:0] id0;
        logic kl;
        bit quiet, stable;
        gid = -1;
        #1;
        n = 0;
        while (bus.req_ready == 0 && n < 40) begin step(); n++; end
        chk("grant_wait", n < 40, 1);
        if (n >= 40) return;
        g = exp_grant(m_last, bus.req_valid);
        chk("req_ready", bus.req_ready, 1 << g);
        d      = bus.req_block[128*g +: 128];
        kl     = cfg_keylen;
        m_last = g;
        gid    = g;
        p0     = next_pulses;
        step();
        chk("core_next_t1", core_next, 1);
        chk("core_block", core_block, d);
        chk("core_keylen", core_keylen, kl);
        bus.req_block[128*g +: 128] = rand128();
        cfg_keylen = 1'($urandom_range(0, 1));
        if (!keep) bus.req_valid[g] = 1'b0;
        step();
        chk("core_next_t2", core_next, 0);
        quiet = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 60) begin
            if (bus.req_ready != 0 || core_next) quiet = 1'b0;
            step();
            n++;
        end
        chk("rsp_wait", n < 60, 1);
        chk("busy_quiet", quiet, 1);
        if (n >= 60) return;
        m_ops++;
        chk("rsp_id", bus.rsp_id, g);
        chk("rsp_block", bus.rsp_block, cipher(d, kl));
        chk("ops_done", ops_done, m_ops[15:0]);
        blk0   = bus.rsp_block;
        id0    = bus.rsp_id;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (bus.rsp_block !== blk0 || bus.rsp_id !== id0 || !bus.rsp_valid ||
                bus.req_ready != 0 || core_next) stable = 1'b0;
        end
        if (hold > 0) chk("rsp_hold_stable", stable, 1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 0);
        chk("next_pulse_count", next_pulses - p0, 1);
    endtask

    initial begin
        int gid;
        reset_n       = 1'b1;
        key_ready     = 1'b1;
        cfg_keylen    = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_block[128*i +: 128] = rand128();
        step();
        do_reset();
        check_reset_values("rst");

        // AES-128 known answer on requester 1
        bus.req_block[128*1 +: 128] = PT;
        bus.req_valid = 4'b0010;
        run_op(0, 1'b0, gid);
        chk("kat128_ops", ops_done, 1);

        // AES-256 known answer on requester 0
        cfg_keylen = 1'b1;
        bus.req_block[128*0 +: 128] = PT;
        bus.req_valid = 4'b0001;
        run_op(0, 1'b0, gid);
        chk("kat256_id", gid, 0);
        cfg_keylen = 1'b0;

        // Fairness from a fresh reset: 0,1,2,3,0,1,2,3
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_op(0, 1'b1, gid);
            chk("fair_order", gid, i % NUM_REQ);
        end

        // Backpressure with every requester pending
        run_op(20, 1'b1, gid);
        bus.req_valid = '0;
        #1;

        // key_ready gating
        key_ready = 1'b0;
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gate_no_ready", bus.req_ready, 0);
        end
        key_ready = 1'b1;
        #1;
        chk("gate_release_grant", bus.req_ready, 4'b0100);
        run_op(0, 1'b0, gid);

        // Reset in BUSY discards the in-flight operation
        bus.req_valid = 4'b1111;
        #1;
        step();
        step();
        chk("pre_reset_busy", core_next, 0);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) step();
        reset_n = 1'b1;
        m_last  = NUM_REQ - 1;
        m_ops   = 0;
        bus.req_valid = '0;
        step();
        chk("post_reset_no_rsp", bus.rsp_valid, 0);
        bus.req_valid = 4'b1000;
        run_op(0, 1'b0, gid);
        chk("post_reset_ops", ops_done, 1);

        // Randomised traffic against the reference model
        for (int t = 0; t < 30; t++) begin
            bus.req_valid = 4'($urandom_range(1, 15));
            cfg_keylen    = 1'($urandom_range(0, 1));
            key_ready     = 1'b1;
            run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), gid);
        end

        chk("never_multi_hot", multi_hot, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
